seg_scan_driver: RTL and testbench

Multiplexed 4-digit 7-segment display driver: the consuming end of the stopwatch digit interface. Takes the four BCD digits produced by the timer (minutes tens/ones, seconds tens/ones) and time-multiplexes them onto a common-anode display. A frame-aligned shadow register prevents tearing. The selected field blinks while in adjust mode.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/seg_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg_scan_driver.sv | 121 ++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: glyphs, digit slots, anode idle value.
package seg_pkg;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit slot order, rightmost first
    localparam logic [1:0] IDX_SEC_O = 2'd0;
    localparam logic [1:0] IDX_SEC_T = 2'd1;
    localparam logic [1:0] IDX_MIN_O = 2'd2;
    localparam logic [1:0] IDX_MIN_T = 2'd3;

    localparam logic [3:0] AN_OFF = 4'hF;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decode; non-BCD values go blank.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    // Glyph lookup, blank for anything above 9
    always_comb begin
        glyph = SEG_BLANK;
        case (digit)
            4'd0: glyph = GLYPH_0;
            4'd1: glyph = GLYPH_1;
            4'd2: glyph = GLYPH_2;
            4'd3: glyph = GLYPH_3;
            4'd4: glyph = GLYPH_4;
            4'd5: glyph = GLYPH_5;
            4'd6: glyph = GLYPH_6;
            4'd7: glyph = GLYPH_7;
            4'd8: glyph = GLYPH_8;
            4'd9: glyph = GLYPH_9;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed common-anode display driver with frame-aligned shadow
// capture and blinking of the selected field in adjust mode.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [3:0] sec_o,
    input  logic [2:0] sec_t,
    input  logic [3:0] min_o,
    input  logic [2:0] min_t,
    input  logic       ADJ,
    input  logic       SEL,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [1:0]    idx;
    logic          tick;

    logic [3:0] sh_sec_o;
    logic [2:0] sh_sec_t;
    logic [3:0] sh_min_o;
    logic [2:0] sh_min_t;

    logic [3:0] cur_digit;
    logic [6:0] cur_glyph;
    logic       pair_hit;
    logic       blank;

    assign tick = (scan_cnt == SW'(SCAN_DIV - 1));

    // Slot timer and digit index
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_cnt <= '0;
            idx      <= IDX_SEC_O;
        end else if (tick) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Shadows load only at frame start so one frame never mixes two times
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sh_sec_o <= '0;
            sh_sec_t <= '0;
            sh_min_o <= '0;
            sh_min_t <= '0;
        end else if (tick && idx == IDX_MIN_T) begin
            sh_sec_o <= sec_o;
            sh_sec_t <= sec_t;
            sh_min_o <= min_o;
            sh_min_t <= min_t;
        end
    end

    // Blink phase; parked visible outside adjust so entry starts with a lit half
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!ADJ) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Select the shadow digit for the current slot
    always_comb begin
        cur_digit = '0;
        case (idx)
            IDX_SEC_O: cur_digit = sh_sec_o;
            IDX_SEC_T: cur_digit = {1'b0, sh_sec_t};
            IDX_MIN_O: cur_digit = sh_min_o;
            IDX_MIN_T: cur_digit = {1'b0, sh_min_t};
            default:   cur_digit = '0;
        endcase
    end

    bcd_to_seg u_dec (
        .digit (cur_digit),
        .glyph (cur_glyph)
    );

    // SEL and ADJ are used live so a change shows on the very next output
    assign pair_hit = SEL ? idx[1] : ~idx[1];
    assign blank    = ADJ && !blink_on && pair_hit;

    // Registered outputs; anodes keep scanning while blanked to hold brightness
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= blank ? SEG_BLANK : cur_glyph;
            dp  <= (idx != IDX_MIN_O);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_DIV=16.
// Posedge k after reset release outputs slot floor((k-1)/4) mod 4;
// shadows load on posedges 16, 32, 48, ...
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [3:0] sec_o;
    logic [2:0] sec_t;
    logic [3:0] min_o;
    logic [2:0] min_t;
    logic       ADJ;
    logic       SEL;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .sec_o   (sec_o),
        .sec_t   (sec_t),
        .min_o   (min_o),
        .min_t   (min_t),
        .ADJ     (ADJ),
        .SEL     (SEL),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // Posedges since reset release
    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the negedge following posedge k
    task automatic run_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        chk({tag, ".an"},  {12'd0, an},  {12'd0, ea});
        chk({tag, ".seg"}, {9'd0, seg},  {9'd0, es});
        chk({tag, ".dp"},  {15'd0, dp},  {15'd0, ed});
    endtask

    initial begin
        RESET_N = 1'b0;
        sec_o = 4'd0; sec_t = 3'd0; min_o = 4'd0; min_t = 3'd0;
        ADJ = 1'b0; SEL = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("reset", 4'hF, 7'h7F, 1'b1);

        RESET_N = 1'b1;
        sec_o = 4'd2; sec_t = 3'd4; min_o = 4'd9; min_t = 3'd5;

        // First frame still shows reset shadows (digit 0)
        run_to(1);  chk_out("first",    4'hE, 7'h40, 1'b1);
        run_to(5);  chk_out("f0_idx1",  4'hD, 7'h40, 1'b1);
        run_to(9);  chk_out("f0_idx2",  4'hB, 7'h40, 1'b0);

        // Basic scan after the first wrap: 5 9 . 4 2
        run_to(17); chk_out("scan_0",   4'hE, 7'h24, 1'b1);
        run_to(21); chk_out("scan_1",   4'hD, 7'h19, 1'b1);

        // Mid-frame input change must wait for the next frame start
        sec_o = 4'd7; min_t = 3'd3;
        run_to(25); chk_out("scan_2",   4'hB, 7'h10, 1'b0);
        run_to(29); chk_out("tear_min_t", 4'h7, 7'h12, 1'b1);
        run_to(33); chk_out("new_sec_o",  4'hE, 7'h78, 1'b1);
        run_to(45); chk_out("new_min_t",  4'h7, 7'h30, 1'b1);

        // Blink seconds: visible P49..P64, blanked P65..P80
        run_to(48); ADJ = 1'b1; SEL = 1'b0;
        run_to(49); chk_out("blk_vis0",  4'hE, 7'h78, 1'b1);
        run_to(61); chk_out("blk_vis3",  4'h7, 7'h30, 1'b1);
        run_to(64); chk_out("blk_last",  4'h7, 7'h30, 1'b1);
        run_to(65); chk_out("blk_off0",  4'hE, 7'h7F, 1'b1);
        run_to(69); chk_out("blk_off1",  4'hD, 7'h7F, 1'b1);
        run_to(73); chk_out("blk_min_lit", 4'hB, 7'h10, 1'b0);
        run_to(81); chk_out("blk_on_again", 4'hE, 7'h78, 1'b1);

        // Second off half P97..P112: switch SEL mid-off
        run_to(97); chk_out("off2_idx0", 4'hE, 7'h7F, 1'b1);
        SEL = 1'b1;
        run_to(98); chk_out("sel_sec_lit", 4'hE, 7'h78, 1'b1);
        run_to(105); chk_out("sel_min_blank", 4'hB, 7'h7F, 1'b0);
        ADJ = 1'b0;
        run_to(106); chk_out("adj_release", 4'hB, 7'h10, 1'b0);

        // Invalid digit, loaded at P112
        sec_o = 4'hC;
        run_to(113); chk_out("invalid", 4'hE, 7'h7F, 1'b1);
        run_to(117); chk_out("after_invalid", 4'hD, 7'h19, 1'b1);

        // Asynchronous reset mid-frame
        run_to(118);
        #2 RESET_N = 1'b0;
        #1 chk_out("async_reset", 4'hF, 7'h7F, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
